// File: rtl/mem_copy_engine.sv
// Block-copy bus initiator: moves 32-bit words from RAM/ROM into RAM
// over the shared data-memory port, arbitrated by bus_req/bus_gnt.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle copy request, sampled only when idle
//   src_addr, dst_addr  byte addresses latched with start
//   len_words           word count latched with start (0 allowed)
//   bus_req, bus_gnt    memory-port request / grant handshake
//   mem_we, mem_a       write enable and byte address to memory
//   mem_wd, mem_rd      write data out, combinational read data in
//   busy                high while requesting, reading or writing
//   done                one-cycle end-of-operation pulse
//   err                 last start was rejected; held until next start
module mem_copy_engine #(
  parameter int RAM_TOP  = 1020,
  parameter int ROM_BASE = 1024,
  parameter int ROM_TOP  = 2044,
  parameter int LEN_W    = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      src_addr,
  input  logic [31:0]      dst_addr,
  input  logic [LEN_W-1:0] len_words,
  output logic             bus_req,
  input  logic             bus_gnt,
  output logic             mem_we,
  output logic [31:0]      mem_a,
  output logic [31:0]      mem_wd,
  input  logic [31:0]      mem_rd,
  output logic             busy,
  output logic             done,
  output logic             err
);

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    RD,
    WR,
    DONE
  } state_t;

  localparam logic [33:0] RAM_TOP_W  = 34'(RAM_TOP);
  localparam logic [33:0] ROM_BASE_W = 34'(ROM_BASE);
  localparam logic [33:0] ROM_TOP_W  = 34'(ROM_TOP);

  state_t state;
  state_t state_nx;

  logic [31:0]      src_cur;
  logic [31:0]      dst_cur;
  logic [31:0]      data_q;
  logic [LEN_W-1:0] rem_q;
  logic             err_q;

  // Range checks run on the raw request inputs. The end addresses are
  // computed two bits wider than the bus so that a huge base address
  // cannot wrap around and masquerade as an in-range block.
  logic        len_nz;
  logic [33:0] len_m1;
  logic [33:0] span;
  logic [33:0] src_w;
  logic [33:0] src_last;
  logic [33:0] dst_last;
  logic        misalign;
  logic        dst_bad;
  logic        src_in_ram;
  logic        src_in_rom;
  logic        src_bad;
  logic        req_bad;

  always_comb begin
    len_nz     = |len_words;
    len_m1     = 34'(len_words) - 34'd1;
    span       = {len_m1[31:0], 2'b00};
    src_w      = {2'b00, src_addr};
    src_last   = src_w + span;
    dst_last   = {2'b00, dst_addr} + span;
    misalign   = (|src_addr[1:0]) | (|dst_addr[1:0]);
    dst_bad    = len_nz && (dst_last > RAM_TOP_W);
    src_in_ram = src_last <= RAM_TOP_W;
    src_in_rom = (src_w >= ROM_BASE_W) &&
                 (src_last <= ROM_TOP_W);
    src_bad    = len_nz && !(src_in_ram || src_in_rom);
    req_bad    = misalign | dst_bad | src_bad;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      src_cur <= '0;
      dst_cur <= '0;
      data_q  <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            src_cur <= src_addr;
            dst_cur <= dst_addr;
            rem_q   <= len_words;
            err_q   <= req_bad;
          end
        end
        RD: begin
          if (bus_gnt) begin
            data_q <= mem_rd;
          end
        end
        WR: begin
          if (bus_gnt) begin
            src_cur <= src_cur + 32'd4;
            dst_cur <= dst_cur + 32'd4;
            rem_q   <= rem_q - LEN_W'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    bus_req  = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    mem_we   = 1'b0;
    mem_a    = '0;
    mem_wd   = '0;
    unique case (state)
      IDLE: begin
        if (start) begin
          if (req_bad || !len_nz) begin
            state_nx = DONE;
          end else begin
            state_nx = REQ;
          end
        end
      end
      REQ: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        if (bus_gnt) begin
          state_nx = RD;
        end
      end
      RD: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        mem_a   = src_cur;
        if (bus_gnt) begin
          state_nx = WR;
        end
      end
      WR: begin
        bus_req = 1'b1;
        busy    = 1'b1;
        mem_a   = dst_cur;
        mem_wd  = data_q;
        // The write only lands on a granted cycle; while stalled the
        // captured word is simply held, so the source is never re-read.
        mem_we  = bus_gnt;
        if (bus_gnt) begin
          if (rem_q == LEN_W'(1)) begin
            state_nx = DONE;
          end else begin
            state_nx = RD;
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign err = err_q;

endmodule
